// File: rtl/memory_stage.sv
// EX/MEM pipeline register with data-cache access control for the 5-stage MIPS pipeline.
// Holds one memory-stage instruction, issues its dcache access, stalls until dhit, and feeds MEM/WB and forwarding.
module memory_stage #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        ex_flush,
  input  logic [31:0] nPC_in,
  input  logic        dREN_in,
  input  logic        dWEN_in,
  input  logic        regWr_in,
  input  logic [2:0]  regSel_in,
  input  logic [4:0]  regDst_in,
  input  logic [31:0] ALUOut_in,
  input  logic [31:0] rtdat_in,
  input  logic        halt_in,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        fwd_regWr,
  output logic [4:0]  fwd_regDst,
  output logic [31:0] fwd_data,
  output logic        wb_regWr,
  output logic [2:0]  wb_regSel,
  output logic [4:0]  wb_regDst,
  output logic [31:0] wb_ALUOut,
  output logic [31:0] wb_dmemload,
  output logic [31:0] wb_nPC,
  output logic        wb_halt,
  output logic        timeout_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] npc;
    logic        dren;
    logic        dwen;
    logic        regwr;
    logic [2:0]  regsel;
    logic [4:0]  regdst;
    logic [31:0] aluout;
    logic [31:0] rtdat;
    logic        halt;
  } minstr_t;

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_t      state_q, state_d;
  minstr_t     m_q, ex_m;
  logic [31:0] loadbuf_q;
  logic [31:0] load_data;
  logic [7:0]  waitcnt_q;
  logic        timeout_q;
  logic        advance;
  logic        req_hit;
  logic        ex_is_mem;

  always_comb begin
    ex_m = '0;
    if (!ex_flush) begin
      ex_m.npc    = nPC_in;
      ex_m.dren   = dREN_in;
      ex_m.dwen   = dWEN_in;
      ex_m.regwr  = regWr_in;
      ex_m.regsel = regSel_in;
      ex_m.regdst = regDst_in;
      ex_m.aluout = ALUOut_in;
      ex_m.rtdat  = rtdat_in;
      ex_m.halt   = halt_in;
    end
  end

  // Dcache handshake: the request (dmemREN/dmemWEN) is the valid and dhit is the ready.
  // The request is held while in REQ, the transfer completes on the first cycle both are
  // high, and the request is dropped on the following cycle so it is never reissued.
  assign req_hit   = (state_q == REQ) & dhit;
  assign mem_stall = (state_q == REQ) & ~dhit;
  assign advance   = ihit & ~mem_stall & (state_q != HALT);
  assign ex_is_mem = ex_m.dren | ex_m.dwen;
  assign load_data = req_hit ? dmemload : loadbuf_q;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == HALT) begin
      state_d = HALT;
    end else if (advance) begin
      if (m_q.halt)       state_d = HALT;
      else if (ex_is_mem) state_d = REQ;
      else                state_d = IDLE;
    end else if (req_hit) begin
      state_d = DONE;
    end
  end

  assign dmemREN    = (state_q == REQ) & m_q.dren;
  assign dmemWEN    = (state_q == REQ) & m_q.dwen;
  assign dmemaddr   = m_q.aluout;
  assign dmemstore  = m_q.rtdat;
  assign fwd_regWr  = m_q.regwr;
  assign fwd_regDst = m_q.regdst;
  assign dbg_state  = state_q;
  assign timeout_err = timeout_q;

  always_comb begin
    case (m_q.regsel)
      3'd1:    fwd_data = load_data;
      3'd2:    fwd_data = m_q.npc;
      default: fwd_data = m_q.aluout;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      m_q         <= '0;
      loadbuf_q   <= '0;
      waitcnt_q   <= '0;
      timeout_q   <= 1'b0;
      wb_regWr    <= 1'b0;
      wb_regSel   <= '0;
      wb_regDst   <= '0;
      wb_ALUOut   <= '0;
      wb_dmemload <= '0;
      wb_nPC      <= '0;
      wb_halt     <= 1'b0;
    end else begin
      if (advance) begin
        m_q         <= ex_m;
        wb_regWr    <= m_q.regwr;
        wb_regSel   <= m_q.regsel;
        wb_regDst   <= m_q.regdst;
        wb_ALUOut   <= m_q.aluout;
        wb_dmemload <= load_data;
        wb_nPC      <= m_q.npc;
        wb_halt     <= m_q.halt;
      end
      if (req_hit) loadbuf_q <= dmemload;
      // The access keeps waiting after a timeout; the flag only reports it.
      if (advance && (state_d == REQ)) begin
        waitcnt_q <= '0;
      end else if (mem_stall && (waitcnt_q < LIMIT)) begin
        waitcnt_q <= waitcnt_q + 8'd1;
      end
      if (mem_stall && (waitcnt_q >= LIMIT - 8'd1)) timeout_q <= 1'b1;
    end
  end

endmodule
